// File: rtl/dl_pkg.sv
// Shared types and constants for the delay_line block.
// The optional burst feature (GAP state) is enabled by defining DL_BURST_EN.
package dl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        PULSE,
        DONE
`ifdef DL_BURST_EN
        , GAP
`endif
    } dl_state_t;

    localparam logic [1:0] MLT_X1    = 2'd0;
    localparam logic [1:0] MLT_X100  = 2'd1;
    localparam logic [1:0] MLT_X100K = 2'd2;
    localparam logic [1:0] MLT_HALT  = 2'd3;

    localparam int unsigned TB_X1    = 1;
    localparam int unsigned TB_X100  = 100;
    localparam int unsigned TB_X100K = 100000;

    // Wide enough to hold TB_X100K - 1.
    localparam int PS_W = 17;

    function automatic int unsigned div_of(input logic [1:0] sel);
        case (sel)
            MLT_X1:    return TB_X1;
            MLT_X100:  return TB_X100;
            MLT_X100K: return TB_X100K;
            default:   return TB_X1;
        endcase
    endfunction

endpackage

// File: rtl/dl_prescaler.sv
// Timebase prescaler: one-clock tick every div_of(sel) clocks, no ticks when halted.
module dl_prescaler
    import dl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [1:0] sel,
    output logic       tick
);

    logic [PS_W-1:0] count;
    logic [PS_W-1:0] last;
    logic            halted;

    assign halted = (sel == MLT_HALT);
    assign last   = PS_W'(div_of(sel) - 1);
    assign tick   = ~halted & (count == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || halted) begin
            count <= '0;
        end else if (count == last) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/delay_line.sv
// Launch-triggered delayed pulse generator with selectable timebase.
// Defining DL_BURST_EN adds burst/gap inputs and a GAP state for pulse trains.
module delay_line
    import dl_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             clk_DL,
    input  logic             rst_n,
    input  logic             launch_DL,
    input  logic [1:0]       dl_mlt,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
`ifdef DL_BURST_EN
    input  logic [7:0]       burst,
    input  logic [CNT_W-1:0] gap,
`endif
    output logic             DL_out,
    output logic             launch_next,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    dl_state_t        state, next_state;
    logic             launch_d, armed, rise, start;
    logic             ps_clr, tick;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] delay_l, width_l, width_eff;
    logic [1:0]       mlt_l;
`ifdef DL_BURST_EN
    logic [7:0]       burst_l, pcnt, pcnt_next;
    logic [CNT_W-1:0] gap_l, gap_eff;

    assign gap_eff = (gap_l == '0) ? ONE : gap_l;
`endif

    // armed blocks a launch level that was already high when reset released.
    assign rise      = launch_DL & ~launch_d & armed;
    assign width_eff = (width_l == '0) ? ONE : width_l;
    assign busy      = (state != IDLE);

    dl_prescaler u_prescaler (
        .clk   (clk_DL),
        .rst_n (rst_n),
        .clr   (ps_clr),
        .sel   (mlt_l),
        .tick  (tick)
    );

    always_ff @(posedge clk_DL or negedge rst_n) begin
        if (!rst_n) begin
            launch_d <= 1'b0;
            armed    <= 1'b0;
        end else begin
            launch_d <= launch_DL;
            if (!launch_DL) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_DL or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            DL_out      <= 1'b0;
            launch_next <= 1'b0;
            delay_l     <= '0;
            width_l     <= '0;
            mlt_l       <= MLT_X1;
`ifdef DL_BURST_EN
            pcnt        <= '0;
            burst_l     <= '0;
            gap_l       <= '0;
`endif
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            DL_out      <= (next_state == PULSE);
            launch_next <= (next_state == DONE);
`ifdef DL_BURST_EN
            pcnt        <= pcnt_next;
`endif
            if (start) begin
                delay_l <= delay;
                width_l <= width;
                mlt_l   <= dl_mlt;
`ifdef DL_BURST_EN
                burst_l <= burst;
                gap_l   <= gap;
`endif
            end
        end
    end

    // DELAY compares before counting so delay=0 leaves on the first clock;
    // PULSE/GAP end on the tick that brings the count up to their length.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        ps_clr     = 1'b0;
        start      = 1'b0;
`ifdef DL_BURST_EN
        pcnt_next  = pcnt;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = DELAY;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
                    start      = 1'b1;
`ifdef DL_BURST_EN
                    pcnt_next  = '0;
`endif
                end
            end
            DELAY: begin
                if (!launch_DL) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
                end else if (cnt == delay_l) begin
                    next_state = PULSE;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
                end else if (tick) begin
                    cnt_next = cnt + ONE;
                end
            end
            PULSE: begin
                if (!launch_DL) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
`ifdef DL_BURST_EN
                    pcnt_next  = '0;
`endif
                end else if (tick) begin
                    if ((cnt + ONE) == width_eff) begin
                        cnt_next = '0;
                        ps_clr   = 1'b1;
`ifdef DL_BURST_EN
                        if (({1'b0, pcnt} + 9'd1) < {1'b0, burst_l}) begin
                            next_state = GAP;
                            pcnt_next  = pcnt + 8'd1;
                        end else begin
                            next_state = DONE;
                        end
`else
                        next_state = DONE;
`endif
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
            end
`ifdef DL_BURST_EN
            GAP: begin
                if (!launch_DL) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                    ps_clr     = 1'b1;
                    pcnt_next  = '0;
                end else if (tick) begin
                    if ((cnt + ONE) == gap_eff) begin
                        next_state = PULSE;
                        cnt_next   = '0;
                        ps_clr     = 1'b1;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
            end
`endif
            DONE: begin
                if (!launch_DL) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line; the burst scenario runs when DL_BURST_EN is defined.
module tb_delay_line;

    localparam int CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             launch_DL;
    logic [1:0]       dl_mlt;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
`ifdef DL_BURST_EN
    logic [7:0]       burst;
    logic [CNT_W-1:0] gap;
`endif
    logic             DL_out;
    logic             launch_next;
    logic             busy;

    int errors = 0;
    int checks = 0;

    delay_line #(.CNT_W(CNT_W)) dut (
        .clk_DL      (clk),
        .rst_n       (rst_n),
        .launch_DL   (launch_DL),
        .dl_mlt      (dl_mlt),
        .delay       (delay),
        .width       (width),
`ifdef DL_BURST_EN
        .burst       (burst),
        .gap         (gap),
`endif
        .DL_out      (DL_out),
        .launch_next (launch_next),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [1:0] m, input int d, input int w);
        launch_DL = l;
        dl_mlt    = m;
        delay     = CNT_W'(d);
        width     = CNT_W'(w);
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first_high;
        int highs;
        logic seen;
        logic all_busy;

        rst_n = 1'b0;
`ifdef DL_BURST_EN
        burst = 8'd0;
        gap   = '0;
`endif
        applyStimulus(1'b0, 2'd0, 0, 0);
        #1;
        checkOutput("reset DL_out", DL_out, 0);
        checkOutput("reset launch_next", launch_next, 0);
        checkOutput("reset busy", busy, 0);
        waitNeg(2);
        rst_n = 1'b1;
        waitNeg(2);

        // Basic sequence: delay 5, width 3, inputs disturbed while busy
        applyStimulus(1'b0, 2'd0, 5, 3);
        waitNeg(1);
        launch_DL = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t1 DL_out k=%0d", k), DL_out, (k >= 6 && k <= 8));
            checkOutput($sformatf("t1 launch_next k=%0d", k), launch_next, (k >= 9));
            checkOutput($sformatf("t1 busy k=%0d", k), busy, 1);
            if (k == 1) begin
                delay  = '0;
                width  = CNT_W'(20);
                dl_mlt = 2'd3;
            end
        end
        launch_DL = 1'b0;
        @(negedge clk);
        checkOutput("t1 release launch_next", launch_next, 0);
        checkOutput("t1 release busy", busy, 0);
        waitNeg(2);

        // delay=0, width=0: single one-cycle pulse right after DELAY entry
        applyStimulus(1'b1, 2'd0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t2 DL_out k=%0d", k), DL_out, (k == 1));
            checkOutput($sformatf("t2 launch_next k=%0d", k), launch_next, (k >= 2));
        end
        launch_DL = 1'b0;
        waitNeg(2);

        // Abort mid-PULSE, then restart
        applyStimulus(1'b1, 2'd0, 2, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t3 DL_out k=%0d", k), DL_out, (k >= 3));
        end
        launch_DL = 1'b0;
        @(negedge clk);
        checkOutput("t3 abort DL_out", DL_out, 0);
        checkOutput("t3 abort busy", busy, 0);
        seen = launch_next;
        repeat (10) begin
            @(negedge clk);
            seen = seen | launch_next;
        end
        checkOutput("t3 no launch_next", seen, 0);
        applyStimulus(1'b1, 2'd0, 1, 2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t3r DL_out k=%0d", k), DL_out, (k == 2 || k == 3));
            checkOutput($sformatf("t3r launch_next k=%0d", k), launch_next, (k >= 4));
        end
        launch_DL = 1'b0;
        waitNeg(2);

        // Reset during DELAY with launch held, then reset during PULSE
        applyStimulus(1'b1, 2'd0, 3, 10);
        waitNeg(2);
        checkOutput("t4 busy before reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4 async busy", busy, 0);
        checkOutput("t4 async launch_next", launch_next, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | busy;
        end
        checkOutput("t4 no restart while held", seen, 0);
        launch_DL = 1'b0;
        @(negedge clk);
        launch_DL = 1'b1;
        waitNeg(5);
        checkOutput("t4 restart DL_out", DL_out, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4 async DL_out drop", DL_out, 0);
        checkOutput("t4 async busy drop", busy, 0);
        launch_DL = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        waitNeg(2);

        // 100-clock timebase: delay 2, width 1
        applyStimulus(1'b1, 2'd1, 2, 1);
        first_high = -1;
        highs      = 0;
        all_busy   = 1'b1;
        for (int k = 0; k < 306; k++) begin
            @(negedge clk);
            if (DL_out) begin
                highs++;
                if (first_high < 0) first_high = k;
            end
            all_busy = all_busy & busy;
        end
        checkOutput("t5 first high", first_high, 201);
        checkOutput("t5 high count", highs, 100);
        checkOutput("t5 busy throughout", all_busy, 1);
        checkOutput("t5 launch_next", launch_next, 1);
        launch_DL = 1'b0;
        waitNeg(2);

        // Halted timebase stalls until aborted
        applyStimulus(1'b1, 2'd3, 1, 1);
        waitNeg(20);
        checkOutput("t6 halted busy", busy, 1);
        checkOutput("t6 halted DL_out", DL_out, 0);
        launch_DL = 1'b0;
        @(negedge clk);
        checkOutput("t6 abort busy", busy, 0);
        checkOutput("t6 abort launch_next", launch_next, 0);
        waitNeg(2);

`ifdef DL_BURST_EN
        // Burst of three 2-cycle pulses with 2-cycle gaps
        begin
            logic [13:0] exp_dl;
            exp_dl = 14'b00_0110_0110_0110;
            burst  = 8'd3;
            gap    = CNT_W'(2);
            applyStimulus(1'b1, 2'd0, 0, 2);
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                checkOutput($sformatf("t7 DL_out k=%0d", k), DL_out, exp_dl[k]);
                checkOutput($sformatf("t7 launch_next k=%0d", k), launch_next, (k >= 11));
            end
            launch_DL = 1'b0;
            waitNeg(2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter CNT_W, default 17, width of the delay, width and gap counters.
REQ-002 clk_DL  input  1  block clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 launch_DL  input  1  launch level from the upstream pulse stage; a rising edge starts a sequence, and a low level aborts or releases it.
REQ-005 dl_mlt  input  2  timebase select: 0 = 1 clock, 1 = 100 clocks, 2 = 100000 clocks, 3 = halted (no ticks).
REQ-006 delay  input  CNT_W  delay from launch to pulse start, in ticks.
REQ-007 width  input  CNT_W  output pulse width in ticks; 0 is treated as 1.
REQ-008 DL_out  output  1  delayed output pulse.
REQ-009 launch_next  output  1  done level, used to chain the next stage.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The block shall register launch_DL once and detect its rising edge as (launch_DL & ~launch_d).
REQ-012 The FSM shall have the states IDLE, DELAY, PULSE and DONE (plus GAP, see REQ-030).
REQ-013 A rising edge in IDLE shall latch delay, width and dl_mlt, clear the tick counter and the prescaler, and move to DELAY on the next clock.
REQ-014 Prescaler: a counter clears when it reaches div-1 and emits a tick for exactly one clock at that point.
REQ-015 Prescaler: the first tick after a start shall occur div clocks after entry to DELAY.
REQ-016 Prescaler: mode 3 shall emit no ticks, so the sequence stalls until it is aborted.
REQ-017 DELAY: each tick shall increment the counter; when the counter equals the latched delay, the FSM shall move to PULSE and clear the counter.
REQ-018 delay = 0 shall move DELAY to PULSE on the first clock in DELAY, without waiting for a tick.
REQ-019 PULSE: DL_out shall be 1 and registered; each tick shall increment the counter, and the FSM shall move to DONE when the counter equals max(width,1).
REQ-020 DONE: launch_next shall be 1 while launch_DL stays high.
REQ-021 DONE: launch_DL low shall return the FSM to IDLE and clear launch_next on the same clock.
REQ-022 Abort: launch_DL low while in DELAY, PULSE or GAP shall force IDLE on the next clock and clear DL_out and the counters.
REQ-023 Abort: launch_next shall not assert after an abort.
REQ-024 Rising edges of launch_DL outside IDLE shall be ignored.
REQ-025 Input changes to delay, width or dl_mlt while busy shall have no effect until the next start.
REQ-026 Counter compares shall be equality on CNT_W bits; no wrap-around is reachable.

Reset
REQ-027 While rst_n is low, the state shall be IDLE, and DL_out, launch_next, busy, launch_d and all counters shall be 0.
REQ-028 Reset mid-sequence shall drop DL_out immediately, without waiting for a clock.
REQ-029 After rst_n is released, a launch_DL that is already high shall not start a sequence until it has gone low and then high again.

Configuration
REQ-030 With DL_BURST_EN defined, the block shall add inputs burst[7:0] and gap[CNT_W-1:0], latched at start.
REQ-031 With DL_BURST_EN defined, PULSE end shall go to GAP if fewer than burst pulses have been emitted, otherwise to DONE.
REQ-032 With DL_BURST_EN defined, GAP shall count gap ticks (gap = 0 means one clock) and then return to PULSE.
REQ-033 With DL_BURST_EN defined, burst values 0 and 1 shall give a single pulse.
REQ-034 Without DL_BURST_EN, the burst and gap ports and the GAP state shall be absent, and behaviour shall be a single pulse.

Structure
REQ-035 The package dl_pkg shall hold the state enum, the timebase constants (1, 100, 100000) and the dl_mlt encodings.
REQ-036 The prescaler shall be a separate sub-module, dl_prescaler (ports: clk, rst_n, clr, sel, tick).

Verification
REQ-037 dl_mlt=0, delay=5, width=3, launch_DL rising at cycle 0 -> DL_out high for cycles 7-9 (REQ-013 to REQ-019), and launch_next rising in the cycle after DL_out falls.
REQ-038 dl_mlt=1, delay=2, width=1 -> DL_out rises about 200 clocks after start and is high for 100 clocks; busy stays high throughout.
REQ-039 delay=0, width=0, dl_mlt=0 -> DL_out is high for exactly 1 cycle, immediately after entry to DELAY.
REQ-040 launch_DL dropped mid-PULSE -> DL_out is 0 on the next clock, FSM is in IDLE, and launch_next never asserts; a second rising edge then restarts normally.
REQ-041 rst_n pulsed low during DELAY with launch_DL held high -> all outputs are 0 asynchronously, and there is no restart until launch_DL toggles.
REQ-042 DL_BURST_EN defined, burst=3, gap=2, width=2, dl_mlt=0 -> three 2-cycle pulses separated by 2-cycle gaps, then launch_next.
